// File: rtl/fetch_sequencer.sv
// Fetch sequencer: walks the fetch PC through a handshaked instruction memory,
// holds each fetched word for decode and drops responses made stale by a redirect.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        pcsrc_i,
   input  logic [31:0] result_i,
   input  logic        stall_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] instr_o,
   output logic        instr_valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus_4_o,
   output logic        fetch_err_o
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
   localparam logic [XLEN-1:0]  WORD_BYTES = XLEN'(4);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_KILL,
      S_HOLD
   } state_e;

   state_e             state_q, state_d;
   logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
   logic               imem_req_q, imem_req_d;
   logic [XLEN-1:0]    imem_addr_q, imem_addr_d;
   logic [XLEN-1:0]    instr_q, instr_d;
   logic               instr_valid_q, instr_valid_d;
   logic [XLEN-1:0]    pc_q, pc_d;
   logic               fetch_err_q, fetch_err_d;
   logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

   logic [XLEN-1:0]    redirect_pc;
   logic [CNT_W-1:0]   wait_cnt_inc;

   assign redirect_pc  = result_i & ~XLEN'(3);
   assign wait_cnt_inc = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);

   // Next-state and registered-output logic
   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      imem_req_d    = imem_req_q;
      imem_addr_d   = imem_addr_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      pc_d          = pc_q;
      wait_cnt_d    = wait_cnt_q;

      unique case (state_q)
         S_IDLE: begin
            state_d     = S_REQ;
            imem_req_d  = 1'b1;
            imem_addr_d = fetch_pc_q;
         end
         S_REQ: begin
            if (imem_ack_i) begin
               wait_cnt_d = '0;
               if (pcsrc_i) begin
                  fetch_pc_d  = redirect_pc;
                  imem_addr_d = redirect_pc;
               end else begin
                  instr_d       = imem_rdata_i;
                  pc_d          = fetch_pc_q;
                  instr_valid_d = 1'b1;
                  fetch_pc_d    = fetch_pc_q + WORD_BYTES;
                  imem_req_d    = 1'b0;
                  state_d       = S_HOLD;
               end
            end else begin
               wait_cnt_d = wait_cnt_inc;
               if (pcsrc_i) begin
                  fetch_pc_d = redirect_pc;
                  state_d    = S_KILL;
               end
            end
         end
         // Old request still on the bus; its response is dropped when it lands
         S_KILL: begin
            if (imem_ack_i) begin
               wait_cnt_d  = '0;
               state_d     = S_REQ;
               fetch_pc_d  = pcsrc_i ? redirect_pc : fetch_pc_q;
               imem_addr_d = pcsrc_i ? redirect_pc : fetch_pc_q;
            end else begin
               wait_cnt_d = wait_cnt_inc;
               if (pcsrc_i) begin
                  fetch_pc_d = redirect_pc;
               end
            end
         end
         S_HOLD: begin
            if (pcsrc_i) begin
               instr_valid_d = 1'b0;
               fetch_pc_d    = redirect_pc;
               imem_req_d    = 1'b1;
               imem_addr_d   = redirect_pc;
               state_d       = S_REQ;
            end else if (!stall_i) begin
               instr_valid_d = 1'b0;
               imem_req_d    = 1'b1;
               imem_addr_d   = fetch_pc_q;
               state_d       = S_REQ;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      fetch_err_d = fetch_err_q | (wait_cnt_d == CNT_MAX);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= S_IDLE;
         fetch_pc_q    <= RESET_PC;
         imem_req_q    <= 1'b0;
         imem_addr_q   <= RESET_PC;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         pc_q          <= RESET_PC;
         fetch_err_q   <= 1'b0;
         wait_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         imem_req_q    <= imem_req_d;
         imem_addr_q   <= imem_addr_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         pc_q          <= pc_d;
         fetch_err_q   <= fetch_err_d;
         wait_cnt_q    <= wait_cnt_d;
      end
   end

   assign imem_req_o    = imem_req_q;
   assign imem_addr_o   = imem_addr_q;
   assign instr_o       = instr_q;
   assign instr_valid_o = instr_valid_q;
   assign pc_o          = pc_q;
   assign pc_plus_4_o   = pc_q + WORD_BYTES;
   assign fetch_err_o   = fetch_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized run scored
// against a PC-stream model with a stale-response flag.
module tb_fetch_sequencer;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int unsigned TIMEOUT  = 16;

   logic        clk;
   logic        reset;
   logic        pcsrc;
   logic [31:0] result;
   logic        stall;
   logic        ack;
   logic [31:0] rdata;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus_4;
   logic        fetch_err;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   assign rdata = ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

   fetch_sequencer #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .pcsrc_i       (pcsrc),
      .result_i      (result),
      .stall_i       (stall),
      .imem_req_o    (imem_req),
      .imem_addr_o   (imem_addr),
      .imem_ack_i    (ack),
      .imem_rdata_i  (rdata),
      .instr_o       (instr),
      .instr_valid_o (instr_valid),
      .pc_o          (pc),
      .pc_plus_4_o   (pc_plus_4),
      .fetch_err_o   (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; pcsrc = 1'b0; stall = 1'b0; ack = 1'b0; result = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({imem_req, imem_addr, instr, instr_valid, pc, pc_plus_4, fetch_err} !==
          {1'b0, RESET_PC, 32'h0, 1'b0, RESET_PC, RESET_PC + 32'd4, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_state: req=%b addr=%h instr=%h valid=%b pc=%h pc4=%h err=%b",
                  imem_req, imem_addr, instr, instr_valid, pc, pc_plus_4, fetch_err);
      end
      // redirect while idle must not move the first fetch
      pcsrc = 1'b1; result = 32'h0000_0080;
      step();
      pcsrc = 1'b0;
      n_checks++;
      if ({imem_req, imem_addr, instr_valid} !== {1'b1, RESET_PC, 1'b0}) begin
         n_fail++;
         $display("FAIL idle_pcsrc_ignored: req=%b addr=%h valid=%b expected 1 %h 0",
                  imem_req, imem_addr, instr_valid, RESET_PC);
      end
   endtask

   task automatic test_sequential();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         step();
         n_checks++;
         if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'(4 * k), 1'b0}) begin
            n_fail++;
            $display("FAIL seq_req[%0d]: req=%b addr=%h valid=%b expected 1 %h 0",
                     k, imem_req, imem_addr, instr_valid, 32'(4 * k));
         end
         ack = 1'b1;
         step();
         ack = 1'b0;
         n_checks++;
         if ({instr_valid, pc, pc_plus_4, instr, imem_req} !==
             {1'b1, 32'(4 * k), 32'(4 * k + 4), mem_word(32'(4 * k)), 1'b0}) begin
            n_fail++;
            $display("FAIL seq_hold[%0d]: valid=%b pc=%h pc4=%h instr=%h req=%b expected pc %h",
                     k, instr_valid, pc, pc_plus_4, instr, imem_req, 32'(4 * k));
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      step(); ack = 1'b1;
      step(); ack = 1'b0;
      step(); ack = 1'b1;
      step(); ack = 1'b0;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if ({instr_valid, pc, instr, imem_req} !== {1'b1, 32'h4, mem_word(32'h4), 1'b0}) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: valid=%b pc=%h instr=%h req=%b expected 1 4 %h 0",
                     i, instr_valid, pc, instr, imem_req, mem_word(32'h4));
         end
      end
      stall = 1'b0;
      step();
      n_checks++;
      if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h8, 1'b0}) begin
         n_fail++;
         $display("FAIL stall_release: req=%b addr=%h valid=%b expected 1 8 0",
                  imem_req, imem_addr, instr_valid);
      end
   endtask

   // Continues from the first REQ cycle for 0x8 left by test_stall
   task automatic test_redirect_kill();
      pcsrc = 1'b1; result = 32'h0000_0100; ack = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         pcsrc = 1'b0;
         n_checks++;
         if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h8, 1'b0}) begin
            n_fail++;
            $display("FAIL kill_wait[%0d]: req=%b addr=%h valid=%b expected 1 8 0",
                     i, imem_req, imem_addr, instr_valid);
         end
      end
      ack = 1'b1;
      step();
      n_checks++;
      if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h100, 1'b0}) begin
         n_fail++;
         $display("FAIL kill_drop: req=%b addr=%h valid=%b expected 1 100 0",
                  imem_req, imem_addr, instr_valid);
      end
      step();
      ack = 1'b0;
      n_checks++;
      if ({instr_valid, pc, instr} !== {1'b1, 32'h100, mem_word(32'h100)}) begin
         n_fail++;
         $display("FAIL kill_refetch: valid=%b pc=%h instr=%h expected 1 100 %h",
                  instr_valid, pc, instr, mem_word(32'h100));
      end
   endtask

   task automatic test_hold_redirect();
      stall = 1'b1; pcsrc = 1'b1; result = 32'h0000_0203;
      step();
      pcsrc = 1'b0; stall = 1'b0;
      n_checks++;
      if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h200}) begin
         n_fail++;
         $display("FAIL hold_redirect: valid=%b req=%b addr=%h expected 0 1 200",
                  instr_valid, imem_req, imem_addr);
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
      n_checks++;
      if ({instr_valid, pc} !== {1'b1, 32'h200}) begin
         n_fail++;
         $display("FAIL hold_redirect_fetch: valid=%b pc=%h expected 1 200", instr_valid, pc);
      end
   endtask

   task automatic test_wrap();
      pcsrc = 1'b1; result = 32'hFFFF_FFFF;
      step();
      pcsrc = 1'b0;
      n_checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
         n_fail++;
         $display("FAIL wrap_req: req=%b addr=%h expected 1 fffffffc", imem_req, imem_addr);
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
      n_checks++;
      if ({instr_valid, pc, pc_plus_4, instr} !==
          {1'b1, 32'hFFFF_FFFC, 32'h0, mem_word(32'hFFFF_FFFC)}) begin
         n_fail++;
         $display("FAIL wrap_hold: valid=%b pc=%h pc4=%h instr=%h expected 1 fffffffc 0",
                  instr_valid, pc, pc_plus_4, instr);
      end
      step();
      n_checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL wrap_next: req=%b addr=%h expected 1 0", imem_req, imem_addr);
      end
      // ack and redirect together in REQ: data dropped, new address next cycle
      ack = 1'b1; pcsrc = 1'b1; result = 32'h0000_0040;
      step();
      pcsrc = 1'b0;
      n_checks++;
      if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h40, 1'b0}) begin
         n_fail++;
         $display("FAIL req_ack_redirect: req=%b addr=%h valid=%b expected 1 40 0",
                  imem_req, imem_addr, instr_valid);
      end
      step();
      ack = 1'b0;
      n_checks++;
      if ({instr_valid, pc, instr} !== {1'b1, 32'h40, mem_word(32'h40)}) begin
         n_fail++;
         $display("FAIL req_ack_redirect_fetch: valid=%b pc=%h instr=%h expected 1 40",
                  instr_valid, pc, instr);
      end
   endtask

   task automatic test_timeout_reset();
      do_reset();
      step();
      for (int k = 1; k <= 18; k++) begin
         step();
         n_checks++;
         if ({fetch_err, imem_req, imem_addr} !== {(k >= 16), 1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL timeout[%0d]: err=%b req=%b addr=%h expected err %0b",
                     k, fetch_err, imem_req, imem_addr, (k >= 16));
         end
      end
      reset = 1'b1; ack = 1'b1;
      step();
      reset = 1'b0;
      n_checks++;
      if ({imem_req, fetch_err, instr_valid, instr} !== {1'b0, 1'b0, 1'b0, 32'h0}) begin
         n_fail++;
         $display("FAIL reset_mid_req: req=%b err=%b valid=%b instr=%h expected 0 0 0 0",
                  imem_req, fetch_err, instr_valid, instr);
      end
      step();
      n_checks++;
      if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL idle_ack_ignored: req=%b addr=%h valid=%b expected 1 0 0",
                  imem_req, imem_addr, instr_valid);
      end
      step();
      ack = 1'b0;
      n_checks++;
      if ({instr_valid, pc, instr, fetch_err} !== {1'b1, 32'h0, mem_word(32'h0), 1'b0}) begin
         n_fail++;
         $display("FAIL restart_fetch: valid=%b pc=%h instr=%h err=%b expected 1 0",
                  instr_valid, pc, instr, fetch_err);
      end
   endtask

   task automatic test_random();
      logic        e_req, e_valid, e_err, stale;
      logic [31:0] e_addr, e_pc, e_instr, next_pc, tgt;
      int unsigned wcnt;
      do_reset();
      e_req = 1'b0; e_valid = 1'b0; e_err = 1'b0; stale = 1'b0;
      e_addr = RESET_PC; e_pc = RESET_PC; e_instr = '0; next_pc = RESET_PC; wcnt = 0;
      for (int i = 0; i < 3000; i++) begin
         n_checks++;
         if ({imem_req, instr_valid, fetch_err} !== {e_req, e_valid, e_err}) begin
            n_fail++;
            $display("FAIL rand_ctrl[%0d]: req/valid/err=%b%b%b expected %b%b%b",
                     i, imem_req, instr_valid, fetch_err, e_req, e_valid, e_err);
         end
         if (e_req) begin
            n_checks++;
            if (imem_addr !== e_addr) begin
               n_fail++;
               $display("FAIL rand_addr[%0d]: addr=%h expected %h", i, imem_addr, e_addr);
            end
         end
         n_checks++;
         if ({pc, pc_plus_4, instr} !== {e_pc, e_pc + 32'd4, e_instr}) begin
            n_fail++;
            $display("FAIL rand_instr[%0d]: pc=%h pc4=%h instr=%h expected %h %h %h",
                     i, pc, pc_plus_4, instr, e_pc, e_pc + 32'd4, e_instr);
         end

         stall = ($urandom_range(0, 2) == 0);
         pcsrc = ($urandom_range(0, 7) == 0);
         ack   = ($urandom_range(0, 9) < 6);
         result = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom);
         tgt = result & ~32'h3;

         if (e_req) begin
            if (ack) begin
               wcnt = 0;
               if (pcsrc) begin
                  next_pc = tgt; stale = 1'b0; e_addr = tgt;
               end else if (stale) begin
                  stale = 1'b0; e_addr = next_pc;
               end else begin
                  e_valid = 1'b1; e_pc = e_addr; e_instr = mem_word(e_addr);
                  next_pc = e_addr + 32'd4; e_req = 1'b0;
               end
            end else begin
               if (wcnt < TIMEOUT) wcnt++;
               if (wcnt == TIMEOUT) e_err = 1'b1;
               if (pcsrc) begin
                  next_pc = tgt; stale = 1'b1;
               end
            end
         end else if (e_valid) begin
            if (pcsrc) begin
               next_pc = tgt; e_valid = 1'b0; e_req = 1'b1; e_addr = tgt;
            end else if (!stall) begin
               e_valid = 1'b0; e_req = 1'b1; e_addr = next_pc;
            end
         end else begin
            e_req = 1'b1; e_addr = next_pc;
         end
         step();
      end
      pcsrc = 1'b0; ack = 1'b0; stall = 1'b0;
   endtask

   initial begin
      reset = 1'b1; pcsrc = 1'b0; stall = 1'b0; ack = 1'b0; result = '0;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_kill();
      test_hold_redirect();
      test_wrap();
      test_timeout_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
